seg_display_sched: RTL and testbench

Scheduler that shares the single 4-digit seven-segment display datapath among three value sources (e.g. score, timer, status code). It arbitrates round-robin with a minimum dwell time and urgent preemption for source 0. It drives the selected 13-bit value and a blank strobe into the display datapath. After every owner change it blanks the display for a settle window, so the iterative base-10 digit extraction never shows partially converted digits.

---
 rtl/seg_display_sched_if.sv | 17 +
 rtl/seg_display_sched.sv | 110 +++++++++++
 tb/tb_seg_display_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg_display_sched_if.sv
// Source-side bundle for the shared seven-segment display: per-source requests
// and values in, selected owner, value and blank strobe out.
interface seg_display_sched_if #(
  parameter int W = 13
);
  logic [2:0]   req;
  logic [W-1:0] val0;
  logic [W-1:0] val1;
  logic [W-1:0] val2;
  logic [2:0]   grant;
  logic [W-1:0] value;
  logic         blank;
  logic         switch;

  modport master (output req, val0, val1, val2, input grant, value, blank, switch);
  modport slave  (input req, val0, val1, val2, output grant, value, blank, switch);
endinterface

// File: rtl/seg_display_sched.sv
// Round-robin owner scheduler for the shared 4-digit display, with minimum dwell,
// source-0 preemption and a blanked settle window after every owner change.
module seg_display_sched #(
  parameter int W      = 13,
  parameter int HOLD   = 64,
  parameter int SETTLE = 4
) (
  input  logic                dclk18,
  input  logic                rst,
  seg_display_sched_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SHOW} state_t;

  localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] HOLD8    = 8'(HOLD);

  state_t            state, state_n;
  logic [1:0]        owner, owner_n, last, last_n;
  logic [3:0]        settle_cnt, settle_n;
  logic [7:0]        dwell_cnt, dwell_n;
  logic [2:0][W-1:0] vals;
  logic [1:0]        refi, drop_pick, rot_pick;
  logic [2:0]        others;

  assign vals = {bus.val2, bus.val1, bus.val0};

  // First set bit of m, scanning from (r0+1) mod 3; falls back to r0 itself.
  function automatic logic [1:0] rr(input logic [1:0] r0, input logic [2:0] m);
    logic [1:0] a, b;
    case (r0)
      2'd0:    begin a = 2'd1; b = 2'd2; end
      2'd1:    begin a = 2'd2; b = 2'd0; end
      default: begin a = 2'd0; b = 2'd1; end
    endcase
    if (m[a])      return a;
    else if (m[b]) return b;
    else           return r0;
  endfunction

  // Source 0 wins any fresh pick; a dwell rotation only looks at the others.
  assign refi      = (state == S_IDLE) ? last : owner;
  assign drop_pick = bus.req[0] ? 2'd0 : rr(refi, bus.req);
  assign others    = bus.req & ~(3'b001 << owner);
  assign rot_pick  = rr(owner, others);

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    last_n   = last;
    settle_n = settle_cnt;
    dwell_n  = dwell_cnt;
    case (state)
      S_IDLE:
        if (|bus.req) begin
          state_n = S_SETTLE; owner_n = drop_pick; settle_n = '0;
        end
      S_SETTLE:
        if (!bus.req[owner]) begin
          if (|bus.req) begin
            owner_n = drop_pick; settle_n = '0;
          end else begin
            state_n = S_IDLE; last_n = owner;
          end
        end else if (settle_cnt == SET_LAST) begin
          state_n = S_SHOW; dwell_n = '0;
        end else begin
          settle_n = settle_cnt + 4'd1;
        end
      S_SHOW: begin
        dwell_n = (dwell_cnt == HOLD8) ? dwell_cnt : dwell_cnt + 8'd1;
        if (!bus.req[owner]) begin
          if (|bus.req) begin
            state_n = S_SETTLE; owner_n = drop_pick; settle_n = '0;
          end else begin
            state_n = S_IDLE; last_n = owner;
          end
        end else if (bus.req[0] && owner != 2'd0) begin
          state_n = S_SETTLE; owner_n = 2'd0; settle_n = '0;
        end else if (dwell_cnt == HOLD8 && |others) begin
          state_n = S_SETTLE; owner_n = rot_pick; settle_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge dclk18) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 2'd0;
      last       <= 2'd2;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      bus.grant  <= 3'b000;
      bus.value  <= '0;
      bus.blank  <= 1'b1;
      bus.switch <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last       <= last_n;
      settle_cnt <= settle_n;
      dwell_cnt  <= dwell_n;
      bus.grant  <= (state_n == S_IDLE) ? 3'b000 : (3'b001 << owner_n);
      bus.value  <= (state_n == S_IDLE) ? '0 : vals[owner_n];
      bus.blank  <= (state_n != S_SHOW);
      bus.switch <= (state_n != S_IDLE) && ((state == S_IDLE) || (owner_n != owner));
    end
  end
endmodule

// File: tb/tb_seg_display_sched.sv
// Bench for seg_display_sched: a vector table for the basic flow, then hand-built
// sequences for rotation, persistence, preemption and reset; all via a scoreboard.
module tb_seg_display_sched;
  localparam int W      = 13;
  localparam int HOLD   = 64;
  localparam int SETTLE = 4;
  // Dwell counts from 0 on SHOW entry and rotation fires once it reads HOLD.
  localparam int PERIOD = SETTLE + HOLD + 1;

  typedef struct {
    logic [2:0]   grant;
    logic [W-1:0] value;
    logic         blank;
    logic         sw;
  } exp_t;

  typedef struct {
    logic         r;
    logic [2:0]   req;
    logic [W-1:0] v0, v1, v2;
    exp_t         e;
  } vec_t;

  logic dclk18 = 1'b0;
  logic rst    = 1'b1;
  int   nvec   = 0;
  int   nerr   = 0;
  exp_t sb[$];
  vec_t tbl[$];

  seg_display_sched_if #(.W(W)) bus();

  seg_display_sched #(.W(W), .HOLD(HOLD), .SETTLE(SETTLE)) dut (
    .dclk18 (dclk18),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 dclk18 = ~dclk18;

  function automatic exp_t e(input logic [2:0] g, input int val, input logic b, input logic s);
    exp_t x;
    x.grant = g; x.value = W'(val); x.blank = b; x.sw = s;
    return x;
  endfunction

  function automatic vec_t v(input logic r, input logic [2:0] rq, input int a, input int b,
                             input int c, input exp_t x);
    vec_t t;
    t.r = r; t.req = rq; t.v0 = W'(a); t.v1 = W'(b); t.v2 = W'(c); t.e = x;
    return t;
  endfunction

  task automatic step(input vec_t t, input string nm);
    exp_t x;
    @(negedge dclk18);
    rst = t.r; bus.req = t.req; bus.val0 = t.v0; bus.val1 = t.v1; bus.val2 = t.v2;
    sb.push_back(t.e);
    @(posedge dclk18);
    #1;
    x = sb.pop_front();
    nvec++;
    if (bus.grant !== x.grant || bus.value !== x.value || bus.blank !== x.blank ||
        bus.switch !== x.sw) begin
      nerr++;
      $display("FAIL %s: got grant=%b value=%0d blank=%b switch=%b, want grant=%b value=%0d blank=%b switch=%b",
               nm, bus.grant, bus.value, bus.blank, bus.switch, x.grant, x.value, x.blank, x.sw);
    end
  endtask

  initial begin
    bus.req = 3'b000; bus.val0 = '0; bus.val1 = '0; bus.val2 = '0;

    // reset, single source 1, live value change, drops in SHOW and SETTLE, source 0 pick
    tbl.push_back(v(1, 3'b000, 0, 0, 0,      e(3'b000, 0, 1, 0)));
    tbl.push_back(v(1, 3'b000, 0, 0, 0,      e(3'b000, 0, 1, 0)));
    tbl.push_back(v(0, 3'b010, 42, 1234, 555, e(3'b010, 1234, 1, 1)));
    tbl.push_back(v(0, 3'b010, 42, 1234, 555, e(3'b010, 1234, 1, 0)));
    tbl.push_back(v(0, 3'b010, 42, 1234, 555, e(3'b010, 1234, 1, 0)));
    tbl.push_back(v(0, 3'b010, 42, 1234, 555, e(3'b010, 1234, 1, 0)));
    tbl.push_back(v(0, 3'b010, 42, 1234, 555, e(3'b010, 1234, 0, 0)));
    tbl.push_back(v(0, 3'b010, 42, 1234, 555, e(3'b010, 1234, 0, 0)));
    tbl.push_back(v(0, 3'b010, 42, 777, 555,  e(3'b010, 777, 0, 0)));
    tbl.push_back(v(0, 3'b000, 42, 777, 555,  e(3'b000, 0, 1, 0)));
    tbl.push_back(v(0, 3'b100, 42, 777, 555,  e(3'b100, 555, 1, 1)));
    tbl.push_back(v(0, 3'b100, 42, 777, 555,  e(3'b100, 555, 1, 0)));
    tbl.push_back(v(0, 3'b100, 42, 777, 555,  e(3'b100, 555, 1, 0)));
    tbl.push_back(v(0, 3'b000, 42, 777, 555,  e(3'b000, 0, 1, 0)));
    tbl.push_back(v(0, 3'b011, 42, 777, 555,  e(3'b001, 42, 1, 1)));
    tbl.push_back(v(0, 3'b011, 42, 777, 555,  e(3'b001, 42, 1, 0)));
    foreach (tbl[i]) step(tbl[i], $sformatf("table[%0d]", i));

    // fair alternation between sources 1 and 2 over 10 rotations
    step(v(1, 3'b000, 0, 0, 0, e(3'b000, 0, 1, 0)), "rot_reset");
    for (int t = 0; t < PERIOD * 11; t++) begin
      int  p;
      bit  one;
      p   = t % PERIOD;
      one = ((t / PERIOD) % 2) == 0;
      step(v(0, 3'b110, 0, 111, 222,
             e(one ? 3'b010 : 3'b100, one ? 111 : 222, p < SETTLE, p == 0)),
           $sformatf("rotate t=%0d", t));
    end

    // lone requester keeps the display past HOLD with no switch
    step(v(1, 3'b000, 0, 0, 0, e(3'b000, 0, 1, 0)), "solo_reset");
    for (int t = 0; t < HOLD + 20; t++)
      step(v(0, 3'b001, 9, 0, 0, e(3'b001, 9, t < SETTLE, t == 0)), $sformatf("solo t=%0d", t));

    // source 0 preempts owner 2 at dwell 5, then reset mid-SHOW
    step(v(1, 3'b000, 0, 0, 0, e(3'b000, 0, 1, 0)), "pre_reset");
    for (int t = 0; t < 10; t++)
      step(v(0, 3'b100, 0, 0, 7, e(3'b100, 7, t < SETTLE, t == 0)), $sformatf("pre_own2 t=%0d", t));
    for (int t = 0; t < 7; t++)
      step(v(0, 3'b101, 42, 0, 7, e(3'b001, 42, t < SETTLE, t == 0)), $sformatf("preempt t=%0d", t));
    step(v(1, 3'b101, 42, 0, 7, e(3'b000, 0, 1, 0)), "rst_mid_show");
    step(v(0, 3'b110, 42, 5, 7, e(3'b010, 5, 1, 1)), "first_pick_after_rst");

    // owner 1 drops while source 0 rises: 0 wins over round-robin choice 2
    step(v(1, 3'b000, 0, 0, 0, e(3'b000, 0, 1, 0)), "drop_reset");
    for (int t = 0; t < 6; t++)
      step(v(0, 3'b010, 0, 3, 0, e(3'b010, 3, t < SETTLE, t == 0)), $sformatf("drop_own1 t=%0d", t));
    step(v(0, 3'b101, 8, 3, 6, e(3'b001, 8, 1, 1)), "drop_and_req0");
    step(v(0, 3'b101, 8, 3, 6, e(3'b001, 8, 1, 0)), "drop_and_req0_hold");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
